// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   uart_state_t : frame FSM states (IDLE=0 .. STOP=4), common to uart_rx/uart_tx
//   OVERSAMPLE   : baud ticks per bit period
//   START_MID    : tick index at the centre of the start bit
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level. Both flops reset to 1
// so an idle-high serial line does not look like a falling edge at reset exit.
//   i_clk     : destination clock
//   i_reset_n : asynchronous active-low reset
//   i_d       : asynchronous input
//   o_q       : synchronized output, two i_clk cycles behind i_d
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver using a 16x oversampling tick. Frames are start bit, DBIT data
// bits LSB first, optional parity bit, and a stop bit of SB_TICK ticks.
//   i_clk        : system clock
//   i_reset_n    : asynchronous active-low reset
//   i_rx         : serial line, idle high, asynchronous to i_clk
//   i_s_tick     : one-cycle pulse at 16x the baud rate
//   o_dout       : last received word, held until the next frame completes
//   o_rx_done    : one-cycle strobe when a frame completes
//   o_parity_err : parity mismatch on the current o_dout
//   o_frame_err  : stop bit sampled low on the current o_dout
//   o_busy       : FSM is not IDLE
//   o_state      : current FSM state, for observation
//
// Output strobe: o_rx_done is a valid-only push with no ready; o_dout and both
// error flags are valid in the o_rx_done cycle and stay stable until the next
// o_rx_done. A consumer that cannot accept the word simply drops it.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done,
    output logic            o_parity_err,
    output logic            o_frame_err,
    output logic            o_busy,
    output logic [2:0]      o_state
);

    // The tick counter needs a fifth bit only for 1.5 or 2 stop bits.
    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] C_MID      = SW'(START_MID);
    localparam logic [SW-1:0] C_BIT_END  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] C_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] C_LAST_BIT = NW'(DBIT - 1);
    localparam logic          C_ODD      = (PARITY_ODD != 0);
    localparam logic          C_PAR_EN   = (PARITY_EN != 0);

    logic w_rx_s;

    sync_2ff u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_rx),
        .o_q       (w_rx_s)
    );

    uart_state_t     r_state;
    logic [SW-1:0]   r_s_cnt;
    logic [NW-1:0]   r_n_cnt;
    logic [DBIT-1:0] r_b;
    logic            r_par;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_perr;
    logic            r_ferr;

    uart_state_t     w_state_nx;
    logic [SW-1:0]   w_s_cnt_nx;
    logic [NW-1:0]   w_n_cnt_nx;
    logic [DBIT-1:0] w_b_nx;
    logic            w_par_nx;
    logic [DBIT-1:0] w_dout_nx;
    logic            w_done_nx;
    logic            w_perr_nx;
    logic            w_ferr_nx;
    logic            w_par_mismatch;

    // Even parity: data XOR parity bit is 0; odd parity inverts that.
    assign w_par_mismatch = C_PAR_EN & ((^r_b) ^ r_par ^ C_ODD);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_b     <= '0;
            r_par   <= 1'b0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_s_cnt <= w_s_cnt_nx;
            r_n_cnt <= w_n_cnt_nx;
            r_b     <= w_b_nx;
            r_par   <= w_par_nx;
            r_dout  <= w_dout_nx;
            r_done  <= w_done_nx;
            r_perr  <= w_perr_nx;
            r_ferr  <= w_ferr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_s_cnt_nx = r_s_cnt;
        w_n_cnt_nx = r_n_cnt;
        w_b_nx     = r_b;
        w_par_nx   = r_par;
        w_dout_nx  = r_dout;
        w_done_nx  = 1'b0;
        w_perr_nx  = r_perr;
        w_ferr_nx  = r_ferr;

        case (r_state)
            IDLE: begin
                // Leaving IDLE does not wait for a tick, so a start bit right
                // after the previous stop sample is never missed.
                if (!w_rx_s) begin
                    w_state_nx = START;
                    w_s_cnt_nx = '0;
                end
            end

            START: begin
                if (i_s_tick) begin
                    if (r_s_cnt == C_MID) begin
                        if (!w_rx_s) begin
                            w_state_nx = DATA;
                            w_s_cnt_nx = '0;
                            w_n_cnt_nx = '0;
                        end else begin
                            // Line back high at mid start bit: noise, not a frame.
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_s_cnt_nx = r_s_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (i_s_tick) begin
                    if (r_s_cnt == C_BIT_END) begin
                        w_s_cnt_nx = '0;
                        w_n_cnt_nx = r_n_cnt + 1'b1;
                        // LSB arrives first, so shifting right leaves it in bit 0.
                        w_b_nx     = {w_rx_s, r_b[DBIT-1:1]};
                        if (r_n_cnt == C_LAST_BIT) begin
                            w_state_nx = C_PAR_EN ? PARITY : STOP;
                        end
                    end else begin
                        w_s_cnt_nx = r_s_cnt + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (i_s_tick) begin
                    if (r_s_cnt == C_BIT_END) begin
                        w_par_nx   = w_rx_s;
                        w_s_cnt_nx = '0;
                        w_state_nx = STOP;
                    end else begin
                        w_s_cnt_nx = r_s_cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (i_s_tick) begin
                    if (r_s_cnt == C_STOP_END) begin
                        w_dout_nx  = r_b;
                        w_ferr_nx  = ~w_rx_s;
                        w_perr_nx  = w_par_mismatch;
                        w_done_nx  = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_s_cnt_nx = r_s_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign o_dout       = r_dout;
    assign o_rx_done    = r_done;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;
    assign o_busy       = (r_state != IDLE);
    assign o_state      = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Drives two receivers: u_dut with default parameters on line rx_a, and u_par
// with even parity enabled on line rx_b. Tick every 4 clocks, 64 clocks per bit.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;

    always #5 clk = ~clk;

    initial begin : tick_gen
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            tick = (tcnt == 0);
        end
    end

    // ---------------- DUTs ----------------
    logic [7:0] dout_a, dout_b;
    logic       done_a, done_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;
    logic [2:0] st_a, st_b;

    uart_rx u_dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_rx         (rx_a),
        .i_s_tick     (tick),
        .o_dout       (dout_a),
        .o_rx_done    (done_a),
        .o_parity_err (perr_a),
        .o_frame_err  (ferr_a),
        .o_busy       (busy_a),
        .o_state      (st_a)
    );

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_rx         (rx_b),
        .i_s_tick     (tick),
        .o_dout       (dout_b),
        .o_rx_done    (done_b),
        .o_parity_err (perr_b),
        .o_frame_err  (ferr_b),
        .o_busy       (busy_b),
        .o_state      (st_b)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } cap_t;

    cap_t       cap_a[$];
    cap_t       cap_b[$];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         ndone_a = 0;
    int         ndone_b = 0;
    logic       prev_a = 1'b0;
    logic       prev_b = 1'b0;
    int         wide_a = 0;
    int         wide_b = 0;

    // Captured words model the receive FIFO that o_dout/o_rx_done feed.
    always @(negedge clk) begin
        if (done_a) begin
            cap_a.push_back('{d: dout_a, pe: perr_a, fe: ferr_a});
            ndone_a++;
            if (prev_a) wide_a++;
        end
        if (done_b) begin
            cap_b.push_back('{d: dout_b, pe: perr_b, fe: ferr_b});
            ndone_b++;
            if (prev_b) wide_b++;
        end
        prev_a = done_a;
        prev_b = done_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int cap_size(input logic sel);
        return sel ? cap_b.size() : cap_a.size();
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic sel, input logic v, input int nclk);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] d, input logic has_par,
                              input logic par_bit, input logic stop_bit, input int idle_clks);
        drive_bit(sel, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], BIT_CLKS);
        if (has_par) drive_bit(sel, par_bit, BIT_CLKS);
        if (stop_bit) begin
            drive_bit(sel, 1'b1, BIT_CLKS);
        end else begin
            // Low past the stop sample point, then back high before the bit ends.
            drive_bit(sel, 1'b0, 44);
            drive_bit(sel, 1'b1, BIT_CLKS - 44);
        end
        if (idle_clks > 0) drive_bit(sel, 1'b1, idle_clks);
    endtask

    task automatic wait_cap(input logic sel, input int n, input string name);
        int k;
        k = 0;
        while (cap_size(sel) < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, (cap_size(sel) >= n), 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_dout;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin : main
        cap_t c;
        logic [7:0] e;

        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1};

        // Reset values
        repeat (5) @(posedge clk);
        #1;
        chk("rst_dout_a", dout_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_perr_a", perr_a, 0);
        chk("rst_ferr_a", ferr_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_dout_b", dout_b, 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].sel, vecs[i].par_bit,
                       vecs[i].stop_bit, BIT_CLKS);
            wait_cap(vecs[i].sel, 1, $sformatf("v%0d_done_timeout", i));
            if (vecs[i].sel) c = cap_b.pop_front();
            else             c = cap_a.pop_front();
            chk($sformatf("v%0d_dout", i), c.d, vecs[i].exp_dout);
            chk($sformatf("v%0d_perr", i), c.pe, vecs[i].exp_perr);
            chk($sformatf("v%0d_ferr", i), c.fe, vecs[i].exp_ferr);
            repeat (BIT_CLKS) @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy_after", i), vecs[i].sel ? busy_b : busy_a, 0);
            chk($sformatf("v%0d_single_strobe", i), cap_size(vecs[i].sel), 0);
        end

        // Busy latency and short-glitch rejection on the default receiver
        rx_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("busy_before_sync", busy_a, 0);
        @(posedge clk);
        #1;
        chk("busy_after_sync", busy_a, 1);
        repeat (13) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        chk("glitch_busy", busy_a, 0);
        chk("glitch_no_done", cap_a.size(), 0);
        chk("glitch_dout_held", dout_a, 8'h11);
        chk("glitch_ferr_held", ferr_a, 0);

        // Back-to-back frames with no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        wait_cap(1'b0, 2, "b2b_done_timeout");
        chk("b2b_count", cap_a.size(), 2);
        if (cap_a.size() > 0) chk("fifo_head", cap_a[0].d, 8'h00);
        while (cap_a.size() > 0 && exp_q.size() > 0) begin
            c = cap_a.pop_front();
            e = exp_q.pop_front();
            chk("b2b_order", c.d, e);
            chk("b2b_ferr", c.fe, 0);
        end
        chk("b2b_exp_drained", exp_q.size(), 0);
        cap_a.delete();

        // Reset pulsed during DATA of a 0x5A frame
        drive_bit(1'b0, 1'b0, BIT_CLKS);
        drive_bit(1'b0, 1'b0, BIT_CLKS);
        drive_bit(1'b0, 1'b1, BIT_CLKS);
        drive_bit(1'b0, 1'b0, BIT_CLKS);
        drive_bit(1'b0, 1'b1, 32);
        chk("mid_frame_busy", busy_a, 1);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_dout", dout_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_perr", perr_a, 0);
        chk("mid_rst_ferr", ferr_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        rst_n = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        chk("post_rst_no_done", cap_a.size(), 0);
        chk("post_rst_busy", busy_a, 0);

        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, BIT_CLKS);
        wait_cap(1'b0, 1, "post_rst_done_timeout");
        if (cap_a.size() > 0) begin
            c = cap_a.pop_front();
            chk("post_rst_dout", c.d, 8'h81);
            chk("post_rst_perr", c.pe, 0);
            chk("post_rst_ferr", c.fe, 0);
        end

        // Strobe width and total pulse counts
        chk("strobe_width_a", wide_a, 0);
        chk("strobe_width_b", wide_b, 0);
        chk("total_done_a", ndone_a, 6);
        chk("total_done_b", ndone_b, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end of the UART test path. Recovers start/data/optional parity/stop frames from the asynchronous `i_rx` line using a 16x oversampling tick, and emits each received word with a single-cycle strobe. `o_dout`/`o_rx_done` connect directly to the receive FIFO's `i_w_data`/`i_wr`. The baud tick comes from the shared baud-rate generator.

## Interface
- `DBIT`, 8: data bits per frame, sent LSB first; legal range 5–9.
- `SB_TICK`, 16: ticks in the stop bit; 16, 24 or 32 for 1, 1.5 or 2 stop bits.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.

Ports:
- `i_clk` in 1: system clock; the only clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_rx` in 1: serial line, idle high, asynchronous to `i_clk`.
- `i_s_tick` in 1: one-cycle pulse at 16x the baud rate.
- `o_dout` out `DBIT`: last received word; held until the next frame completes.
- `o_rx_done` out 1: one-cycle strobe when a frame completes.
- `o_parity_err` out 1: parity mismatch on the current `o_dout`; valid with and after `o_rx_done`.
- `o_frame_err` out 1: stop bit sampled low on the current `o_dout`; valid with and after `o_rx_done`.
- `o_busy` out 1: high whenever the state is not IDLE.

## Operation
- `i_rx` passes through a 2-FF synchronizer; both flops reset to 1. All logic uses the synchronized `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP. Counters: `s_cnt` (4 bits, counts ticks) and `n_cnt` (counts data bits, ceil(log2(`DBIT`)) bits).
- IDLE:
  - `rx_s`=0 moves to START and clears `s_cnt`. No tick is needed to leave IDLE.
- START, on ticks only:
  - At `s_cnt`=7 (mid start bit), `rx_s`=0 moves to DATA and clears `s_cnt` and `n_cnt`.
  - `rx_s`=1 at that point is a glitch: return to IDLE with no strobe.
- DATA:
  - At `s_cnt`=15, shift `rx_s` into the MSB of the shift register (right shift), clear `s_cnt`, and increment `n_cnt`.
  - After bit `DBIT`-1, go to PARITY if `PARITY_EN`, otherwise to STOP.
- PARITY:
  - At `s_cnt`=15, latch the parity bit and go to STOP.
  - Error condition: (XOR of data bits) XOR (parity bit) XOR `PARITY_ODD` ≠ 0.
- STOP:
  - At `s_cnt`=`SB_TICK`-1, sample `rx_s`.
  - Register `o_dout`, `o_frame_err` (`rx_s`==0) and `o_parity_err` (forced to 0 when `PARITY_EN`=0).
  - Pulse `o_rx_done` and return to IDLE.
  - `s_cnt` is 5 bits wide when `SB_TICK`>16.
- `o_rx_done` pulses for every completed frame, errored or not. The consumer qualifies it with the error flags.
- Outputs do not change between frames. A glitch-rejected start leaves `o_dout` and both error flags unchanged.
- `o_rx_done` is produced by this block and is not gated by downstream FIFO status. Frames arriving while the FIFO is full are dropped by the FIFO.

## Timing
- Reset values: `o_dout`=0, `o_rx_done`=0, `o_parity_err`=0, `o_frame_err`=0, `o_busy`=0, state IDLE, counters 0.
- Reset asserted mid-frame aborts immediately, with no strobe. After release, the receiver waits for a new falling edge.
- A line edge appears on `rx_s` 2 `i_clk` cycles later. `o_busy` rises on the cycle after `rx_s` falls.
- `o_rx_done` is high for exactly one `i_clk`, in the cycle after the tick where STOP reaches `SB_TICK`-1. `o_dout` is valid in that same cycle.
- `o_busy` falls together with `o_rx_done`.
- Back-to-back frames:
  - A start bit that begins immediately after the stop-sample tick is detected.
  - IDLE reacts to `rx_s`=0 in the first cycle after STOP, so no idle gap is required.
- Counters advance only on `i_s_tick` cycles. With no tick, the FSM holds its state.
- `i_s_tick` is never two cycles wide; no behaviour is defined for that case.

## Structure
- Shared package `uart_pkg` holds the FSM state localparams (IDLE=0 … STOP=4), `OVERSAMPLE`=16, and `START_MID`=7. The same package is shared with `uart_tx`.
- Sub-module `sync_2ff` is the reset-to-1 two-flop synchronizer, reused for the other asynchronous inputs.

## Test plan
- Bench setup: tick every 4 clocks, line driven at 64 clocks per bit.
- Default parameters, send 0xA5 → exactly one `o_rx_done` pulse, `o_dout`=0xA5, both error flags 0, `o_busy` low afterwards.
- Stop bit held low on a 0x3C frame → `o_dout`=0x3C, `o_frame_err`=1, `o_rx_done` pulses. The next good frame 0x11 clears `o_frame_err` to 0.
- `i_rx` low for 4 ticks only, then high → no `o_rx_done`, `o_busy` returns to 0, `o_dout` unchanged.
- `PARITY_EN`=1, even parity:
  - 0x07 with parity bit 1 → `o_parity_err`=0.
  - 0x07 with parity bit 0 → `o_parity_err`=1.
- Back-to-back 0x00 then 0xFF with zero idle gap → two pulses, in order 0x00 then 0xFF. Driving a `fifo` instance, it ends non-empty with 0x00 at the head.
- `i_reset_n` pulsed low during the DATA state of a 0x5A frame → no strobe and all outputs 0. The following full 0x81 frame is received correctly.
